// File: rtl/pix_fifo_pkg.sv
// pix_fifo_pkg: shared constants and sizing helpers for the pixel FIFO.
//   ptr_width(depth)   : pointer width, at least one bit.
//   count_width(depth) : occupancy counter width, wide enough to hold depth itself.
//   DropCountWidth     : width of the optional saturating drop counter.
package pix_fifo_pkg;

    localparam int unsigned DropCountWidth = 16;

    function automatic int unsigned ptr_width(input int unsigned depth);
        int unsigned w;
        w = unsigned'($clog2(depth));
        return (w > 1) ? w : 1;
    endfunction

    function automatic int unsigned count_width(input int unsigned depth);
        return unsigned'($clog2(depth + 1));
    endfunction

endpackage

// File: rtl/pix_fifo_mem.sv
// pix_fifo_mem: Depth x Width storage for pix_fifo.
// Kept in its own module so it can be replaced by a block-RAM implementation.
// Ports:
//   clk   : write clock
//   we    : write enable, writes wdata to mem[waddr] on the rising edge
//   waddr : write address
//   wdata : write data
//   raddr : read address (combinational read)
//   rdata : read data, mem[raddr]
// Contents are deliberately not reset.
module pix_fifo_mem
    import pix_fifo_pkg::*;
#(
    parameter int unsigned Width = 12,
    parameter int unsigned Depth = 3
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [ptr_width(Depth)-1:0]   waddr,
    input  logic [Width-1:0]              wdata,
    input  logic [ptr_width(Depth)-1:0]   raddr,
    output logic [Width-1:0]              rdata
);

    logic [Width-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pix_fifo.sv
// pix_fifo: parametrised synchronous FIFO for image-sensor pixel data.
// Circular buffer of any Depth >= 2 with valid/ready on both sides, simultaneous
// push/pop, occupancy count, sticky overflow and synchronous flush.
// Ports:
//   clk       : pixel clock, rising-edge
//   rst_      : asynchronous active-low reset
//   flush     : synchronous clear of contents and flags (highest priority)
//   din       : write valid
//   dReady    : write ready (not full)
//   d         : write data
//   qout      : read ready (consumer takes q)
//   qValid    : read valid (not empty)
//   q         : head-of-queue data
//   count     : current occupancy
//   overflow  : sticky, set when a write is refused while the consumer is idle
//   dropCount : (only with PIX_FIFO_DROP_COUNT_EN) saturating count of dropped writes
// Optional feature macro: PIX_FIFO_DROP_COUNT_EN.
module pix_fifo
    import pix_fifo_pkg::*;
#(
    parameter int unsigned Width = 12,
    parameter int unsigned Depth = 3
) (
    input  logic                          clk,
    input  logic                          rst_,
    input  logic                          flush,
    input  logic                          din,
    output logic                          dReady,
    input  logic [Width-1:0]              d,
    input  logic                          qout,
    output logic                          qValid,
    output logic [Width-1:0]              q,
    output logic [count_width(Depth)-1:0] count,
`ifdef PIX_FIFO_DROP_COUNT_EN
    output logic [DropCountWidth-1:0]     dropCount,
`endif
    output logic                          overflow
);

    localparam int unsigned PW = ptr_width(Depth);
    localparam int unsigned CW = count_width(Depth);

    localparam logic [PW-1:0] PtrLast  = PW'(Depth - 1);
    localparam logic [CW-1:0] DepthCnt = CW'(Depth);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop, drop;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PtrLast) ? '0 : p + 1'b1;
    endfunction

    assign qValid = (count_q != '0);
    assign dReady = (count_q != DepthCnt);
    assign count  = count_q;

    // dReady is computed from the current count, so a full FIFO refuses din even
    // while it pops; that refusal is not a drop because the consumer is draining.
    assign push = din & dReady;
    assign pop  = qout & qValid;
    assign drop = din & ~dReady & ~qout;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_next(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_next(rd_ptr_q);
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef PIX_FIFO_DROP_COUNT_EN
    logic [DropCountWidth-1:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (flush) begin
            drop_cnt_d = '0;
        end else if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Saturation keeps the counter non-zero once set, so it doubles as the sticky flag.
    assign dropCount = drop_cnt_q;
    assign overflow  = (drop_cnt_q != '0);
`else
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (flush) begin
            ovf_d = 1'b0;
        end else if (drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`endif

    pix_fifo_mem #(
        .Width (Width),
        .Depth (Depth)
    ) u_mem (
        .clk   (clk),
        .we    (push & ~flush),
        .waddr (wr_ptr_q),
        .wdata (d),
        .raddr (rd_ptr_q),
        .rdata (q)
    );

`ifndef SYNTHESIS
    count_max_a : assert property (@(posedge clk) disable iff (!rst_) count_d <= DepthCnt);
    count_min_a : assert property (@(posedge clk) disable iff (!rst_)
                                   (pop && !push) |-> (count_q != '0));
`endif

endmodule
